register_op_scheduler: RTL

Sequencer and two-way arbiter that shares one `Register` instance (FunSel/I/E interface) between two requesters, such as control-unit microsteps and a memory-load path. Single-cycle requests are issued as one enabled FunSel cycle. A 16-bit word load is sequenced as two byte writes: low byte with MSB clear (FunSel 100), then high byte (FunSel 110). This mirrors how the datapath loads words from its 8-bit memory bus.

---
 rtl/reg_ctrl_pkg.sv | 37 +++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/register_op_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the Register control path: FunSel codes, scheduler
// opcodes and the sequencer state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package reg_ctrl_pkg;

  // FunSel codes understood by the Register
  localparam logic [2:0] FS_DEC          = 3'b000;
  localparam logic [2:0] FS_INC          = 3'b001;
  localparam logic [2:0] FS_LOAD         = 3'b010;
  localparam logic [2:0] FS_CLR          = 3'b011;
  localparam logic [2:0] FS_LOADLO_CLRHI = 3'b100;
  localparam logic [2:0] FS_WRLO         = 3'b101;
  localparam logic [2:0] FS_WRHI         = 3'b110;
  localparam logic [2:0] FS_SEXT         = 3'b111;

  // Scheduler opcodes: 0xxx is a direct FunSel, 1000 a two-beat word load,
  // everything above that is reserved.
  localparam logic [3:0] OP_WORD16  = 4'b1000;
  localparam logic [3:0] OP_RSVD_LO = 4'b1001;
  localparam logic [3:0] OP_RSVD_HI = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WORD_HI = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic logic op_is_reserved(input logic [3:0] op);
    return (op >= OP_RSVD_LO) && (op <= OP_RSVD_HI);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter: round-robin on ties (RR!=0) or fixed priority to A (RR==0).
// Latency: winner is combinational from the requests; the history flag updates on take.
// Backpressure: none; the caller only asserts take when it consumes the winner.
// Ports: req_a/req_b requests, take = winner accepted this cycle, winner = chosen requester.
module rr_arbiter2
  import reg_ctrl_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic    Clock,
  input  logic    Reset,
  input  logic    req_a,
  input  logic    req_b,
  input  logic    take,
  output req_id_t winner
);

  req_id_t last_q;

  always_comb begin
    winner = REQ_A;
    if (req_a && req_b) begin
      // tie: round-robin hands it to whoever did not win last time
      winner = ((RR != 0) && (last_q == REQ_A)) ? REQ_B : REQ_A;
    end else if (req_b) begin
      winner = REQ_B;
    end
  end

  // last starts as B so A wins the first tie after reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_q <= REQ_B;
    end else if (take) begin
      last_q <= winner;
    end
  end

endmodule

// File: rtl/register_op_scheduler.sv
// Arbitrates two requesters onto one Register (FunSel/I/E), splitting WORD16 into two byte writes.
// Latency: request seen at edge k -> write at k+1 (single) or k+1/k+2 (WORD16); IDLE between ops.
// Backpressure: requesters hold Req/Op/Data until their Gnt is seen; only IDLE samples requests.
// Ports: Clock/Reset (sync, active-high); ReqA/B, OpA/B, DataA/B in; FunSel, I, E to the Register;
//        GntA/B completion strobes, Busy (not idle), Err (reserved opcode, with its Gnt).
module register_op_scheduler
  import reg_ctrl_pkg::*;
#(
  parameter int N  = 16,  // only 16 is supported
  parameter int RR = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         ReqA,
  input  logic         ReqB,
  input  logic [3:0]   OpA,
  input  logic [3:0]   OpB,
  input  logic [N-1:0] DataA,
  input  logic [N-1:0] DataB,
  output logic [2:0]   FunSel,
  output logic [N-1:0] I,
  output logic         E,
  output logic         GntA,
  output logic         GntB,
  output logic         Busy,
  output logic         Err
);

  state_t       state_q, state_d;
  logic [3:0]   op_q;
  logic [N-1:0] data_q;
  req_id_t      win_q;
  req_id_t      winner;
  logic         take;
  logic         gnt;

  assign take = (state_q == ST_IDLE) && (ReqA || ReqB);

  rr_arbiter2 #(.RR(RR)) u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req_a  (ReqA),
    .req_b  (ReqB),
    .take   (take),
    .winner (winner)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      win_q   <= REQ_A;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q   <= (winner == REQ_B) ? OpB : OpA;
        data_q <= (winner == REQ_B) ? DataB : DataA;
        win_q  <= winner;
      end
    end
  end

  // Outputs decode only from state and captured operands, never from Req.
  always_comb begin
    state_d = state_q;
    E       = 1'b0;
    FunSel  = FS_DEC;
    I       = '0;
    gnt     = 1'b0;
    Err     = 1'b0;
    Busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (ReqA || ReqB) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (op_is_reserved(op_q)) begin
          // register left untouched, requester released with an error flag
          gnt = 1'b1;
          Err = 1'b1;
        end else if (op_q == OP_WORD16) begin
          E       = 1'b1;
          FunSel  = FS_LOADLO_CLRHI;
          I       = {8'h00, data_q[7:0]};
          state_d = ST_WORD_HI;
        end else begin
          E      = 1'b1;
          FunSel = op_q[2:0];
          I      = data_q;
          gnt    = 1'b1;
        end
      end
      ST_WORD_HI: begin
        E       = 1'b1;
        FunSel  = FS_WRHI;
        I       = {8'h00, data_q[15:8]};
        gnt     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset forces the Register interface quiet in the same cycle, so a
    // reset during WORD_HI keeps the high-byte write from landing.
    if (Reset) begin
      E      = 1'b0;
      FunSel = FS_DEC;
      I      = '0;
      gnt    = 1'b0;
      Err    = 1'b0;
      Busy   = 1'b0;
    end
  end

  assign GntA = gnt && (win_q == REQ_A);
  assign GntB = gnt && (win_q == REQ_B);

endmodule
